// File: rtl/key_press_conditioner.sv
// ============================================================================
// Module  : key_press_conditioner
// Purpose : Turns a raw, bouncy, active-low pushbutton into clean one-cycle press pulses,
//           a debounced held level and a modulo-256 press count. Optional auto-repeat
//           is enabled by defining KEY_AUTOREPEAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 384,
    parameter int REPEAT_PERIOD   = 76,
    parameter int RPT_W           = 9
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    output logic       press,
    output logic       held,
    output logic [7:0] press_count
);

`ifdef KEY_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DOWN   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DOWN = 1'b1
    } state_t;
`endif

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             held_q, held_d;
    logic             press_q, press_d;
    logic [7:0]       count_q, count_d;
    state_t           state_q, state_d;
`ifdef KEY_AUTOREPEAT_EN
    logic [RPT_W-1:0] rcnt_q, rcnt_d;
`endif

    // Synchroniser and debounce: held changes only after the synchronised key has
    // disagreed with it for DEBOUNCE_CYCLES+1 consecutive edges.
    always_comb begin
        sync1_d = ~key_n;
        sync2_d = sync1_q;
        dcnt_d  = '0;
        held_d  = held_q;
        if (sync2_q != held_q) begin
            if (dcnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                held_d = ~held_q;
            end else begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end
        end
    end

    // Press FSM reacts to the debounced level in the same edge it changes.
    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        count_d = count_q;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_d  = rcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (held_d) begin
                    state_d = ST_DOWN;
                    press_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rcnt_d  = '0;
`endif
                end
            end
            ST_DOWN: begin
                if (!held_d) begin
                    state_d = ST_IDLE;
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (rcnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                    state_d = ST_REPEAT;
                    press_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + RPT_W'(1);
                end
`endif
            end
`ifdef KEY_AUTOREPEAT_EN
            ST_REPEAT: begin
                if (!held_d) begin
                    state_d = ST_IDLE;
                end else if (rcnt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + RPT_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (press_d) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dcnt_q  <= '0;
            held_q  <= 1'b0;
            press_q <= 1'b0;
            count_q <= 8'd0;
            state_q <= ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q  <= '0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dcnt_q  <= dcnt_d;
            held_q  <= held_d;
            press_q <= press_d;
            count_q <= count_d;
            state_q <= state_d;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    assign press       = press_q;
    assign held        = held_q;
    assign press_count = count_q;

endmodule

`default_nettype wire
